// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Serial receive front end: turns the asynchronous rx line into parallel
// bytes using mid-bit sampling, an optional even-parity check and a stop-bit
// check. Each completed frame lands in a one-entry valid/ready output
// register. Parity and framing errors travel with the byte. A frame that
// completes while the register is still full is dropped and flagged.
//
// Parameters
//   BR          clock cycles per bit (>= 4)
//   DATA_WIDTH  data bits per frame, LSB first (>= 2)
//   PARITY_EN   1 = even parity bit follows the data, 0 = no parity bit
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   rx          asynchronous serial input, idle high
//   rx_data     received byte, valid while rx_vld
//   rx_vld      output register holds an unconsumed byte
//   rx_rdy      consumer accepts the byte when rx_vld && rx_rdy
//   parity_err  parity mismatch for rx_data (0 when PARITY_EN=0)
//   frame_err   stop bit of rx_data was sampled low
//   overrun     one-cycle pulse: completed frame dropped, register was full
module uart_rx_byte #(
  parameter int BR         = 434,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_vld,
  input  logic                  rx_rdy,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int BR_W  = $clog2(BR);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BR_W-1:0]  BR_LAST   = BR_W'(BR - 1);
  localparam logic [BR_W-1:0]  HALF_LAST = BR_W'(BR / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_n;

  logic                  sync_a;
  logic                  sync_b;
  logic                  rx_s;
  logic [BR_W-1:0]       br_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  perr;

  logic                  sample_data;
  logic                  sample_par;
  logic                  sample_stop;
  logic                  br_clr;
  logic                  load;
  logic                  drop;

  // Two-flop synchronizer; resets to the idle (high) line level so that
  // reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= rx;
      sync_b <= sync_a;
    end
  end

  assign rx_s = sync_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT_HIGH;
      br_cnt <= '0;
    end else begin
      state  <= state_n;
      br_cnt <= br_clr ? '0 : br_cnt + 1'b1;
    end
  end

  // Next-state and sample strobes. The START sample lands mid start bit;
  // every later sample is one full bit period on, so all of them are mid-bit.
  always_comb begin
    state_n     = state;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    sample_stop = 1'b0;
    case (state)
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (br_cnt == HALF_LAST) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (br_cnt == BR_LAST) begin
          sample_data = 1'b1;
          if (bit_cnt == BIT_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (br_cnt == BR_LAST) begin
          sample_par = 1'b1;
          state_n    = STOP;
        end
      end
      STOP: begin
        if (br_cnt == BR_LAST) begin
          sample_stop = 1'b1;
          // A low stop bit may be a break; wait for the line to return high.
          state_n     = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      default: state_n = WAIT_HIGH;
    endcase
  end

  // The bit timer restarts on every state change and at each data sample,
  // since DATA stays in one state across all data bits.
  assign br_clr = (state_n != state) || sample_data ||
                  (state == IDLE) || (state == WAIT_HIGH);

  // A finished frame loads if the register is empty or is being emptied
  // in this same cycle; otherwise it is dropped.
  assign load = sample_stop && (!rx_vld || rx_rdy);
  assign drop = sample_stop && rx_vld && !rx_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      perr      <= 1'b0;
    end else begin
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (sample_data) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
      if (sample_data) begin
        shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
      end
      if (state == IDLE) begin
        perr <= 1'b0;
      end else if (sample_par) begin
        perr <= (^shift_reg) ^ rx_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_vld     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= drop;
      if (load) begin
        rx_data    <= shift_reg;
        parity_err <= perr;
        frame_err  <= ~rx_s;
        rx_vld     <= 1'b1;
      end else if (rx_vld && rx_rdy) begin
        rx_vld <= 1'b0;
      end
    end
  end

endmodule
